// File: rtl/kypd_scan.sv
// 4x4 hex keypad scanner: row strobe, column sync, per-scan debounce FSM, 16-bit digit entry.
// Optional build macro KYPD_CLEAR_EN: an accepted key C clears entry instead of shifting in.
module kypd_scan #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        sysclk,
  input  logic        rst,
  input  logic [3:0]  KYPD_COL,
  output logic [3:0]  KYPD_ROW,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_held,
  output logic [15:0] entry
);

  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} state_t;

  state_t          state;
  logic [3:0]      col_s1, col_s2;
  logic [DW-1:0]   div;
  logic [1:0]      row, next_row;
  logic [1:0]      acc_n;
  logic [3:0]      acc_code;
  logic            eval;
  logic [CW-1:0]   cnt, press_next, release_next;
  logic [3:0]      cand;

  logic [3:0]      row_keys;
  logic [1:0]      row_col, row_n, base_n, sum_n;
  logic [2:0]      sum;
  logic [3:0]      sum_code;

  function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'd0:  k = 4'h1;  4'd1:  k = 4'h2;  4'd2:  k = 4'h3;  4'd3:  k = 4'hA;
      4'd4:  k = 4'h4;  4'd5:  k = 4'h5;  4'd6:  k = 4'h6;  4'd7:  k = 4'hB;
      4'd8:  k = 4'h7;  4'd9:  k = 4'h8;  4'd10: k = 4'h9;  4'd11: k = 4'hC;
      4'd12: k = 4'h0;  4'd13: k = 4'hF;  4'd14: k = 4'hE;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  // Fold the current row's sample into the running scan result; count saturates at 2 (MULTI).
  always_comb begin
    row_keys = ~col_s2;
    row_col  = 2'd0;
    if (row_keys == 4'd0)
      row_n = 2'd0;
    else if ((row_keys & (row_keys - 4'd1)) == 4'd0)
      row_n = 2'd1;
    else
      row_n = 2'd2;
    for (int unsigned i = 4; i > 0; i--)
      if (row_keys[i-1]) row_col = 2'(i - 1);
    base_n   = (row == 2'd0) ? 2'd0 : acc_n;
    sum      = {1'b0, base_n} + {1'b0, row_n};
    sum_n    = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    sum_code = (row_n != 2'd0) ? keymap(row, row_col) : acc_code;
  end

  assign next_row     = row + 2'd1;
  assign press_next   = (state == PRESS && acc_code == cand) ? cnt + CW'(1) : CW'(1);
  assign release_next = (state == RELEASE) ? cnt + CW'(1) : CW'(1);

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      col_s1   <= '1;
      col_s2   <= '1;
      div      <= '0;
      row      <= '0;
      KYPD_ROW <= 4'b1110;
      acc_n    <= '0;
      acc_code <= '0;
      eval     <= 1'b0;
    end else begin
      col_s1 <= KYPD_COL;
      col_s2 <= col_s1;
      eval   <= 1'b0;
      if (div == DW'(SCAN_DIV - 1)) begin
        div      <= '0;
        row      <= next_row;
        KYPD_ROW <= ~(4'b0001 << next_row);
        acc_n    <= sum_n;
        acc_code <= sum_code;
        if (row == 2'd3) eval <= 1'b1;
      end else begin
        div <= div + DW'(1);
      end
    end
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      key_held  <= 1'b0;
      entry     <= '0;
    end else begin
      key_valid <= 1'b0;
      if (eval) begin
        case (state)
          IDLE, PRESS: begin
            if (acc_n == 2'd1) begin
              cand <= acc_code;
              if (press_next == CW'(DEBOUNCE_SCANS)) begin
                state     <= HELD;
                cnt       <= '0;
                key_code  <= acc_code;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
`ifdef KYPD_CLEAR_EN
                entry     <= (acc_code == 4'hC) ? '0 : {entry[11:0], acc_code};
`else
                entry     <= {entry[11:0], acc_code};
`endif
              end else begin
                state <= PRESS;
                cnt   <= press_next;
              end
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end
          HELD, RELEASE: begin
            if (acc_n == 2'd0) begin
              if (release_next == CW'(DEBOUNCE_SCANS)) begin
                state    <= IDLE;
                cnt      <= '0;
                key_held <= 1'b0;
              end else begin
                state <= RELEASE;
                cnt   <= release_next;
              end
            end else begin
              state <= HELD;
              cnt   <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_kypd_scan.sv
// Bench for kypd_scan: behavioural keypad matrix, scoreboard of expected key pulses.
module tb_kypd_scan;

  localparam int unsigned SD   = 4;
  localparam int unsigned DB   = 2;
  localparam int unsigned SCAN = 4 * SD;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  col;
  logic [3:0]  row;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic [15:0] entry;

  logic [15:0] mask;
  logic [15:0] exp_entry;
  logic [19:0] sb[$];
  int total = 0;
  int bad   = 0;

  kypd_scan #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .sysclk(clk), .rst(rst), .KYPD_COL(col), .KYPD_ROW(row),
    .key_valid(key_valid), .key_code(key_code), .key_held(key_held), .entry(entry)
  );

  always #5 clk = ~clk;

  // Pressed switch at (r,c) pulls column c low while row r is driven low.
  always_comb begin
    col = 4'b1111;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (mask[r*4 + c] && !row[r]) col[c] = 1'b0;
  end

  function automatic int pos_of(input logic [3:0] code);
    case (code)
      4'h1: return 0;  4'h2: return 1;  4'h3: return 2;  4'hA: return 3;
      4'h4: return 4;  4'h5: return 5;  4'h6: return 6;  4'hB: return 7;
      4'h7: return 8;  4'h8: return 9;  4'h9: return 10; 4'hC: return 11;
      4'h0: return 12; 4'hF: return 13; 4'hE: return 14; default: return 15;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && key_valid === 1'b1) begin
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_pulse observed code=%0h expected no pulse", key_code);
      end
      if (sb.size() != 0) begin
        logic [19:0] e;
        e = sb.pop_front();
        chk("pulse_code", key_code, e[19:16]);
        chk("pulse_entry", entry, e[15:0]);
      end
    end
  end

  task automatic wait_row(input logic [3:0] target);
    int n = 0;
    while (row !== target && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    assert (n < 40) else begin
      bad++;
      $error("FAIL row_wait_timeout observed=%0h expected=%0h", row, target);
    end
  endtask

  task automatic wait_scan_start();
    wait_row(4'b0111);
    wait_row(4'b1110);
  endtask

  task automatic expect_accept(input logic [3:0] code);
`ifdef KYPD_CLEAR_EN
    exp_entry = (code == 4'hC) ? 16'h0000 : {exp_entry[11:0], code};
`else
    exp_entry = {exp_entry[11:0], code};
`endif
    sb.push_back({code, exp_entry});
  endtask

  task automatic press_key(input logic [3:0] code, input int hold, input int rel, input bit accept);
    wait_scan_start();
    mask = 16'h0001 << pos_of(code);
    if (accept) expect_accept(code);
    repeat (hold * SCAN) @(negedge clk);
    chk("held_during", key_held, {31'b0, accept});
    mask = 16'h0000;
    repeat (rel * SCAN) @(negedge clk);
    chk("held_after_release", key_held, 0);
    chk("pulse_pending", sb.size(), 0);
  endtask

  initial begin
    logic [3:0] er;
    rst       = 1'b1;
    mask      = 16'h0000;
    exp_entry = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_row", row, 4'b1110);
    chk("rst_valid", key_valid, 0);
    chk("rst_code", key_code, 0);
    chk("rst_held", key_held, 0);
    chk("rst_entry", entry, 0);

    rst = 1'b0;
    for (int k = 0; k < 4 * SCAN; k++) begin
      er = ~(4'b0001 << ((k / SD) % 4));
      chk("row_seq", row, er);
      @(negedge clk);
    end
    chk("idle_entry", entry, 0);

    press_key(4'h5, 3, 3, 1);
    chk("key5_code", key_code, 4'h5);
    chk("key5_entry", entry, 16'h0005);

    press_key(4'h1, 3, 3, 1);
    press_key(4'h2, 3, 3, 1);
    press_key(4'h3, 3, 3, 1);
    press_key(4'hA, 3, 3, 1);
    press_key(4'h7, 3, 3, 1);
    chk("seq_entry", entry, 16'h23A7);
    chk("seq_code", key_code, 4'h7);

    press_key(4'h9, 1, 3, 0);
    chk("short_entry", entry, 16'h23A7);
    chk("short_code", key_code, 4'h7);

    // Two keys together, then one alone, then the second added back while held.
    wait_scan_start();
    mask = (16'h0001 << pos_of(4'h4)) | (16'h0001 << pos_of(4'h6));
    repeat (4 * SCAN) @(negedge clk);
    chk("multi_held", key_held, 0);
    chk("multi_entry", entry, 16'h23A7);
    wait_scan_start();
    mask = 16'h0001 << pos_of(4'h4);
    expect_accept(4'h4);
    repeat (3 * SCAN) @(negedge clk);
    chk("single4_held", key_held, 1);
    chk("single4_code", key_code, 4'h4);
    mask = (16'h0001 << pos_of(4'h4)) | (16'h0001 << pos_of(4'h6));
    repeat (3 * SCAN) @(negedge clk);
    chk("added6_held", key_held, 1);
    chk("added6_code", key_code, 4'h4);
    mask = 16'h0000;
    repeat (3 * SCAN) @(negedge clk);
    chk("multi_release", key_held, 0);
    chk("multi_pending", sb.size(), 0);

    // Reset while key 8 is part-way through debounce.
    wait_scan_start();
    mask = 16'h0001 << pos_of(4'h8);
    repeat (SCAN + 4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_row", row, 4'b1110);
    chk("mid_rst_valid", key_valid, 0);
    chk("mid_rst_code", key_code, 0);
    chk("mid_rst_held", key_held, 0);
    chk("mid_rst_entry", entry, 0);
    rst = 1'b0;
    exp_entry = 16'h0000;
    expect_accept(4'h8);
    repeat (3 * SCAN) @(negedge clk);
    chk("post_rst_held", key_held, 1);
    chk("post_rst_pending", sb.size(), 0);
    mask = 16'h0000;
    repeat (3 * SCAN) @(negedge clk);
    chk("post_rst_release", key_held, 0);

    press_key(4'h0, 3, 3, 1);
    press_key(4'h1, 3, 3, 1);
    press_key(4'h2, 3, 3, 1);
    press_key(4'h3, 3, 3, 1);
    chk("pre_c_entry", entry, 16'h0123);
    press_key(4'hC, 3, 3, 1);
    chk("c_code", key_code, 4'hC);
    chk("c_entry", entry, exp_entry);

    chk("final_pending", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
